// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and lane-select helper for the MEM-stage
// data-memory responder.
package dmem_pkg;

    localparam logic [2:0] MR_NONE = 3'b000;
    localparam logic [2:0] MR_LB   = 3'b001;
    localparam logic [2:0] MR_LH   = 3'b010;
    localparam logic [2:0] MR_LW   = 3'b011;
    localparam logic [2:0] MR_LBU  = 3'b101;
    localparam logic [2:0] MR_LHU  = 3'b110;

    localparam logic [2:0] MW_NONE = 3'b000;
    localparam logic [2:0] MW_SB   = 3'b001;
    localparam logic [2:0] MW_SH   = 3'b010;
    localparam logic [2:0] MW_SW   = 3'b011;

    // Load and store encodings share their low two bits as the access size.
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    function automatic logic is_load(input logic [2:0] op);
        return (op == MR_LB) || (op == MR_LH) || (op == MR_LW) ||
               (op == MR_LBU) || (op == MR_LHU);
    endfunction

    function automatic logic is_store(input logic [2:0] op);
        return (op == MW_SB) || (op == MW_SH) || (op == MW_SW);
    endfunction

    function automatic logic [3:0] lane_select(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 4'b0001 << addr_lo;
            SZ_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// EX/MEM-to-memory request bus and the BUSY_WAIT/DATA_READED response.
interface data_mem_responder_if;
    logic [2:0]  MEM_READ;
    logic [2:0]  MEM_WRITE;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic        BUSY_WAIT;
    logic [31:0] DATA_READED;
    logic        MISALIGN;

    modport master (
        output MEM_READ, MEM_WRITE, ADDRESS, WRITE_DATA,
        input  BUSY_WAIT, DATA_READED, MISALIGN
    );

    modport slave (
        input  MEM_READ, MEM_WRITE, ADDRESS, WRITE_DATA,
        output BUSY_WAIT, DATA_READED, MISALIGN
    );
endinterface

// File: rtl/dmem_load_extend.sv
// Picks the addressed byte/half out of a memory word and sign- or zero-extends
// it according to the load opcode.
module dmem_load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] raw_word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  load_op,
    output logic [31:0] ext_word
);
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = raw_word[{addr_lo, 3'b000} +: 8];
        half_val = raw_word[{addr_lo[1], 4'b0000} +: 16];
        case (load_op)
            MR_LB:   ext_word = {{24{byte_val[7]}}, byte_val};
            MR_LBU:  ext_word = {24'h0, byte_val};
            MR_LH:   ext_word = {{16{half_val[15]}}, half_val};
            MR_LHU:  ext_word = {16'h0, half_val};
            default: ext_word = raw_word;
        endcase
    end
endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data memory for the MEM stage: stalls via BUSY_WAIT for LATENCY
// cycles per access. Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4
) (
    input  logic               CLK,
    input  logic               RESET,
    data_mem_responder_if.slave bus
);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam int AW    = DEPTH_LOG2 + 2;

    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                store_reg;
    logic [2:0]          op_reg;
    logic [AW-1:0]       addr_reg;
    logic [31:0]         wdata_reg;
    logic [31:0]         data_readed_reg;
    logic                misalign_reg;

    logic [31:0]         mem [0:WORDS-1];

    logic                req_store, req_load, request;
    logic                acc_store, acc_misaligned, access_now, mem_we;
    logic [2:0]          acc_op;
    logic [1:0]          acc_size, eff_lo;
    logic [AW-1:0]       acc_addr;
    logic [31:0]         acc_wdata, load_word;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [3:0]          byte_en;
    logic [3:0][7:0]     store_lanes;
    logic                addr_hi_unused;

    assign req_store      = is_store(bus.MEM_WRITE);
    assign req_load       = is_load(bus.MEM_READ);
    assign request        = req_store || req_load;
    assign addr_hi_unused = ^bus.ADDRESS[31:AW];

    // With LATENCY==1 the access happens in the IDLE cycle, straight from the bus.
    always_comb begin
        if (state_reg == IDLE) begin
            acc_store = req_store;
            acc_op    = req_store ? bus.MEM_WRITE : bus.MEM_READ;
            acc_addr  = bus.ADDRESS[AW-1:0];
            acc_wdata = bus.WRITE_DATA;
        end else begin
            acc_store = store_reg;
            acc_op    = op_reg;
            acc_addr  = addr_reg;
            acc_wdata = wdata_reg;
        end
    end

    assign acc_size = acc_op[1:0];

    always_comb begin
`ifdef DMEM_MISALIGN_TRAP_EN
        acc_misaligned = ((acc_size == SZ_HALF) && acc_addr[0]) ||
                         ((acc_size == SZ_WORD) && (acc_addr[1:0] != 2'b00));
        eff_lo         = acc_addr[1:0];
`else
        acc_misaligned = 1'b0;
        case (acc_size)
            SZ_WORD: eff_lo = 2'b00;
            SZ_HALF: eff_lo = {acc_addr[1], 1'b0};
            default: eff_lo = acc_addr[1:0];
        endcase
`endif
    end

    assign word_idx   = acc_addr[AW-1:2];
    assign byte_en    = lane_select(acc_size, eff_lo);
    assign access_now = ((state_reg == ACCESS) && (cnt_reg == CNT_W'(1))) ||
                        ((LATENCY == 1) && (state_reg == IDLE) && request);
    assign mem_we     = access_now && acc_store && !acc_misaligned && !RESET;

    // Replicate the low byte/half of the store data onto every lane it may target.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign store_lanes[gi] = (acc_size == SZ_BYTE) ? acc_wdata[7:0] :
                                 (acc_size == SZ_HALF) ? acc_wdata[(gi % 2) * 8 +: 8] :
                                                         acc_wdata[gi * 8 +: 8];
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem[word_idx][b * 8 +: 8] <= store_lanes[b];
            end
        end
    end

    dmem_load_extend u_load_extend (
        .raw_word (mem[word_idx]),
        .addr_lo  (eff_lo),
        .load_op  (acc_op),
        .ext_word (load_word)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            store_reg       <= 1'b0;
            op_reg          <= MR_NONE;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            data_readed_reg <= '0;
            misalign_reg    <= 1'b0;
        end else begin
            misalign_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (request) begin
                        store_reg <= acc_store;
                        op_reg    <= acc_op;
                        addr_reg  <= acc_addr;
                        wdata_reg <= acc_wdata;
                        cnt_reg   <= CNT_W'(LATENCY - 1);
                        state_reg <= (LATENCY == 1) ? DONE : ACCESS;
                    end
                end
                ACCESS: begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1)) state_reg <= DONE;
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
            if (access_now) begin
                misalign_reg <= acc_misaligned;
                if (!acc_store) data_readed_reg <= acc_misaligned ? 32'h0 : load_word;
            end
        end
    end

    assign bus.BUSY_WAIT   = !RESET && (((state_reg == IDLE) && request) || (state_reg == ACCESS));
    assign bus.DATA_READED = data_readed_reg;
    assign bus.MISALIGN    = misalign_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: per-cycle behavioural model plus
// hand-computed literal checks. Honours DMEM_MISALIGN_TRAP_EN when defined.
module tb_data_mem_responder;
    localparam int DL   = 8;
    localparam int LAT  = 4;
    localparam int MEMB = 1 << (DL + 2);

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   n_assert = 0;
    int   n_fail = 0;

    data_mem_responder_if dif ();

    data_mem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (dif)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_mem [0:MEMB-1];
    logic [31:0] m_data = 32'h0;
    logic        m_mis = 1'b0;
    int          phase = -1;
    logic        c_store;
    logic [2:0]  c_op;
    logic [31:0] c_addr, c_wd;

    task automatic model_access();
        int n, base, off;
        logic [31:0] v;
        logic mis;
        n   = (c_op == 3'd3) ? 4 : ((c_op == 3'd2) || (c_op == 3'd6)) ? 2 : 1;
        off = int'(c_addr[1:0]) % n;
`ifdef DMEM_MISALIGN_TRAP_EN
        mis  = (off != 0);
        base = int'(c_addr[DL+1:0]);
`else
        mis  = 1'b0;
        base = int'(c_addr[DL+1:0]) - off;
`endif
        if (c_store) begin
            if (!mis) for (int i = 0; i < n; i++) m_mem[base + i] = c_wd[8 * i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v[8 * i +: 8] = m_mem[base + i];
            if (mis) v = 32'h0;
            else if (c_op == 3'd1) v = {{24{v[7]}}, v[7:0]};
            else if (c_op == 3'd2) v = {{16{v[15]}}, v[15:0]};
            m_data = v;
        end
        m_mis = mis;
    endtask

    initial begin
        logic vs, vl, exp_busy;
        @(posedge CLK);
        forever begin
            @(negedge CLK);
            vs = dif.MEM_WRITE inside {3'd1, 3'd2, 3'd3};
            vl = dif.MEM_READ inside {3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
            if (!RESET && phase < 0 && (vs || vl)) begin
                phase   = 0;
                c_store = vs;
                c_op    = vs ? dif.MEM_WRITE : dif.MEM_READ;
                c_addr  = dif.ADDRESS;
                c_wd    = dif.WRITE_DATA;
            end
            exp_busy = !RESET && phase >= 0 && phase < LAT;
            chk("model_busy", {31'h0, dif.BUSY_WAIT}, {31'h0, exp_busy});
            chk("model_data", dif.DATA_READED, m_data);
            chk("model_misalign", {31'h0, dif.MISALIGN}, {31'h0, (phase == LAT) ? m_mis : 1'b0});
            if (RESET) begin
                phase  = -1;
                m_data = 32'h0;
                m_mis  = 1'b0;
            end else if (phase >= 0) begin
                if (phase == LAT - 1) model_access();
                if (phase == LAT) phase = -1;
                else phase++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [2:0] rd, input logic [2:0] wr, input logic [31:0] a, input logic [31:0] wd);
        dif.MEM_READ   = rd;
        dif.MEM_WRITE  = wr;
        dif.ADDRESS    = a;
        dif.WRITE_DATA = wd;
    endtask

    // One full access; returns at mid-cycle of the cycle BUSY_WAIT drops.
    task automatic do_req(input string nm, input logic [2:0] rd, input logic [2:0] wr,
                          input logic [31:0] a, input logic [31:0] wd, input logic do_chk,
                          input logic [31:0] exp, input logic exp_mis);
        int busy_cnt = 0;
        @(posedge CLK); #1;
        drive(rd, wr, a, wd);
        for (int c = 0; c <= LAT; c++) begin
            @(negedge CLK);
            if (dif.BUSY_WAIT) busy_cnt++;
            if (c < LAT) @(posedge CLK);
        end
        $display("txn %-10s rd=%0d wr=%0d addr=%h wdata=%h -> data=%h misalign=%0b busy_cycles=%0d",
                 nm, rd, wr, a, wd, dif.DATA_READED, dif.MISALIGN, busy_cnt);
        chk({nm, "_busy_cycles"}, busy_cnt, LAT);
        if (do_chk) begin
            chk({nm, "_data"}, dif.DATA_READED, exp);
            chk({nm, "_misalign"}, {31'h0, dif.MISALIGN}, {31'h0, exp_mis});
        end
    endtask

    task automatic no_req(input logic [2:0] rd, input logic [2:0] wr, input int n);
        @(posedge CLK); #1;
        drive(rd, wr, 32'h10, 32'h0);
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            chk("invalid_op_busy", {31'h0, dif.BUSY_WAIT}, 32'h0);
            if (c < n - 1) @(posedge CLK);
        end
        $display("txn invalid    rd=%0d wr=%0d held %0d cycles -> busy=%0b", rd, wr, n, dif.BUSY_WAIT);
    endtask

    initial begin
        drive(3'd0, 3'd0, 32'h0, 32'h0);
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        chk("reset_data", dif.DATA_READED, 32'h0);
        chk("reset_busy", {31'h0, dif.BUSY_WAIT}, 32'h0);

        do_req("sw10",  3'd0, 3'd3, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0);
        do_req("lw10",  3'd3, 3'd0, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0);
        do_req("sw20",  3'd0, 3'd3, 32'h20, 32'h44332211, 1'b0, 32'h0, 1'b0);
        do_req("sb21",  3'd0, 3'd1, 32'h21, 32'hFFFFFF80, 1'b1, 32'hDEADBEEF, 1'b0);
        do_req("lb21",  3'd1, 3'd0, 32'h21, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0);
        do_req("lbu21", 3'd5, 3'd0, 32'h21, 32'h0,        1'b1, 32'h00000080, 1'b0);
        do_req("lw20",  3'd3, 3'd0, 32'h20, 32'h0,        1'b1, 32'h44338011, 1'b0);
        do_req("sw30",  3'd0, 3'd3, 32'h30, 32'h0,        1'b0, 32'h0, 1'b0);
        do_req("sh32",  3'd0, 3'd2, 32'h32, 32'h12348001, 1'b0, 32'h0, 1'b0);
        do_req("lh32",  3'd2, 3'd0, 32'h32, 32'h0,        1'b1, 32'hFFFF8001, 1'b0);
        do_req("lhu32", 3'd6, 3'd0, 32'h32, 32'h0,        1'b1, 32'h00008001, 1'b0);
        do_req("lw30",  3'd3, 3'd0, 32'h30, 32'h0,        1'b1, 32'h80010000, 1'b0);
        do_req("both40", 3'd3, 3'd3, 32'h40, 32'h12345678, 1'b1, 32'h80010000, 1'b0);
        do_req("lw40",  3'd3, 3'd0, 32'h40, 32'h0,        1'b1, 32'h12345678, 1'b0);
        do_req("sw50",  3'd0, 3'd3, 32'h50, 32'h11223344, 1'b0, 32'h0, 1'b0);

        // Reset in the second ACCESS cycle of a store abandons it.
        @(posedge CLK); #1;
        drive(3'd0, 3'd3, 32'h50, 32'hAAAAAAAA);
        @(posedge CLK);
        @(posedge CLK); #1 RESET = 1'b1;
        @(negedge CLK);
        chk("rst_mid_busy", {31'h0, dif.BUSY_WAIT}, 32'h0);
        @(posedge CLK); #1 RESET = 1'b0;
        drive(3'd0, 3'd0, 32'h0, 32'h0);
        @(negedge CLK);
        chk("rst_mid_data", dif.DATA_READED, 32'h0);
        $display("txn rst_sw50   reset pulsed mid-access -> data=%h busy=%0b", dif.DATA_READED, dif.BUSY_WAIT);
        do_req("lw50",  3'd3, 3'd0, 32'h50, 32'h0, 1'b1, 32'h11223344, 1'b0);

        no_req(3'd4, 3'd4, 3);
        no_req(3'd7, 3'd5, 2);

`ifdef DMEM_MISALIGN_TRAP_EN
        do_req("lw13",  3'd3, 3'd0, 32'h13, 32'h0, 1'b1, 32'h0, 1'b1);
        do_req("lh33",  3'd2, 3'd0, 32'h33, 32'h0, 1'b1, 32'h0, 1'b1);
        do_req("sw12",  3'd0, 3'd3, 32'h12, 32'h55555555, 1'b1, 32'h0, 1'b1);
`else
        do_req("lw13",  3'd3, 3'd0, 32'h13, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0);
        do_req("lh33",  3'd2, 3'd0, 32'h33, 32'h0, 1'b1, 32'hFFFF8001, 1'b0);
        do_req("sw12",  3'd0, 3'd3, 32'h12, 32'hCAFEF00D, 1'b1, 32'hFFFF8001, 1'b0);
`endif
        do_req("lw410", 3'd3, 3'd0, 32'h410, 32'h0, 1'b0, 32'h0, 1'b0);
        do_req("lw_wrap", 3'd3, 3'd0, 32'hFFFF_0410, 32'h0, 1'b0, 32'h0, 1'b0);

        @(posedge CLK); #1;
        drive(3'd0, 3'd0, 32'h0, 32'h0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
